// File: rtl/axi_mem_pkg.sv
// Shared AXI definitions for the memory bridges (mem2axi, axi2mem): burst and
// response encodings plus the static attribute bundle of an AW/AR request.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    axi_burst_t burst;
    logic       lock;
    logic [3:0] cache;
    logic [3:0] qos;
    logic [3:0] region;
    logic [2:0] prot;
  } ax_req_t;

  // Attributes of a plain single-beat INCR access of 2**size bytes.
  function automatic ax_req_t single_beat(input logic [2:0] size);
    ax_req_t a;
    a       = '0;
    a.size  = size;
    a.burst = BURST_INCR;
    return a;
  endfunction

endpackage

// File: rtl/mem2axi_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) with master and slave views.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]    aw_id;
  logic [AXI_ADDR_WIDTH-1:0]  aw_addr;
  logic [7:0]                 aw_len;
  logic [2:0]                 aw_size;
  axi_mem_pkg::axi_burst_t    aw_burst;
  logic                       aw_lock;
  logic [3:0]                 aw_cache;
  logic [2:0]                 aw_prot;
  logic [3:0]                 aw_qos;
  logic [3:0]                 aw_region;
  logic [5:0]                 aw_atop;
  logic [AXI_USER_WIDTH-1:0]  aw_user;
  logic                       aw_valid;
  logic                       aw_ready;

  logic [AXI_DATA_WIDTH-1:0]  w_data;
  logic [AXI_STRB_WIDTH-1:0]  w_strb;
  logic                       w_last;
  logic [AXI_USER_WIDTH-1:0]  w_user;
  logic                       w_valid;
  logic                       w_ready;

  logic [AXI_ID_WIDTH-1:0]    b_id;
  logic [1:0]                 b_resp;
  logic [AXI_USER_WIDTH-1:0]  b_user;
  logic                       b_valid;
  logic                       b_ready;

  logic [AXI_ID_WIDTH-1:0]    ar_id;
  logic [AXI_ADDR_WIDTH-1:0]  ar_addr;
  logic [7:0]                 ar_len;
  logic [2:0]                 ar_size;
  axi_mem_pkg::axi_burst_t    ar_burst;
  logic                       ar_lock;
  logic [3:0]                 ar_cache;
  logic [2:0]                 ar_prot;
  logic [3:0]                 ar_qos;
  logic [3:0]                 ar_region;
  logic [AXI_USER_WIDTH-1:0]  ar_user;
  logic                       ar_valid;
  logic                       ar_ready;

  logic [AXI_ID_WIDTH-1:0]    r_id;
  logic [AXI_DATA_WIDTH-1:0]  r_data;
  logic [1:0]                 r_resp;
  logic                       r_last;
  logic [AXI_USER_WIDTH-1:0]  r_user;
  logic                       r_valid;
  logic                       r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/mem2axi.sv
// Bridges a single-word req/gnt memory port onto an AXI master; every accepted
// request becomes one single-beat AXI transaction, with at most one in flight.
module mem2axi
  import axi_mem_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_USER_WIDTH-1:0]   user_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic [AXI_USER_WIDTH-1:0]   ruser_o,
  output logic                        err_o,
  AXI_BUS.Master                      master
);

  localparam int unsigned NR_BYTES     = AXI_DATA_WIDTH / 8;
  localparam int unsigned LOG_NR_BYTES = $clog2(NR_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = {AXI_ADDR_WIDTH{1'b1}} << LOG_NR_BYTES;
  localparam ax_req_t AX_ATTR = single_beat(3'(LOG_NR_BYTES));

  typedef enum logic [2:0] {IDLE, AW_W, WAIT_B, AR, WAIT_R} state_t;

  state_t                      state;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [NR_BYTES-1:0]         be_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_USER_WIDTH-1:0]   user_q;
  logic                        aw_valid_q, w_valid_q, ar_valid_q;
  logic                        b_ready_q, r_ready_q;
  logic                        rvalid_q, err_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [AXI_USER_WIDTH-1:0]   ruser_q;
  logic                        aw_hs, w_hs;

  assign aw_hs = aw_valid_q & master.aw_ready;
  assign w_hs  = w_valid_q & master.w_ready;

  assign gnt_o    = req_i && (state == IDLE) && !rst_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign ruser_o  = ruser_q;
  assign err_o    = err_q;

  assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.aw_addr   = addr_q;
  assign master.aw_len    = AX_ATTR.len;
  assign master.aw_size   = AX_ATTR.size;
  assign master.aw_burst  = AX_ATTR.burst;
  assign master.aw_lock   = AX_ATTR.lock;
  assign master.aw_cache  = AX_ATTR.cache;
  assign master.aw_prot   = AX_ATTR.prot;
  assign master.aw_qos    = AX_ATTR.qos;
  assign master.aw_region = AX_ATTR.region;
  assign master.aw_atop   = '0;
  assign master.aw_user   = user_q;
  assign master.aw_valid  = aw_valid_q;

  assign master.w_data  = wdata_q;
  assign master.w_strb  = be_q;
  assign master.w_last  = 1'b1;
  assign master.w_user  = user_q;
  assign master.w_valid = w_valid_q;

  assign master.b_ready = b_ready_q;

  assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.ar_addr   = addr_q;
  assign master.ar_len    = AX_ATTR.len;
  assign master.ar_size   = AX_ATTR.size;
  assign master.ar_burst  = AX_ATTR.burst;
  assign master.ar_lock   = AX_ATTR.lock;
  assign master.ar_cache  = AX_ATTR.cache;
  assign master.ar_prot   = AX_ATTR.prot;
  assign master.ar_qos    = AX_ATTR.qos;
  assign master.ar_region = AX_ATTR.region;
  assign master.ar_user   = user_q;
  assign master.ar_valid  = ar_valid_q;

  assign master.r_ready = r_ready_q;

  // Response ids need no check: only one transaction is ever outstanding.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{master.b_id, master.b_user, master.r_id, master.r_last};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      user_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ruser_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i & ADDR_MASK;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            user_q  <= user_i;
            if (we_i) begin
              state      <= AW_W;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state      <= AR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        // A low valid doubles as the per-channel done flag: each channel
        // finishes independently and B is awaited once both are done.
        AW_W: begin
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs)  w_valid_q  <= 1'b0;
          if ((aw_hs || !aw_valid_q) && (w_hs || !w_valid_q)) begin
            state     <= WAIT_B;
            b_ready_q <= 1'b1;
          end
        end
        WAIT_B: begin
          if (master.b_valid) begin
            state     <= IDLE;
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= (master.b_resp != RESP_OKAY);
            rdata_q   <= '0;
            ruser_q   <= '0;
          end
        end
        AR: begin
          if (master.ar_ready) begin
            state      <= WAIT_R;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        WAIT_R: begin
          if (master.r_valid) begin
            state     <= IDLE;
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= (master.r_resp != RESP_OKAY);
            rdata_q   <= master.r_data;
            ruser_q   <= master.r_user;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem2axi.md
Name: mem2axi

Overview:
- Bridges a simple single-word memory request port (req/gnt/we/addr/be/wdata, registered rvalid response) onto an AXI master port.
- Placed in front of interconnects, so that SRAM-style initiators such as cores, DMAs and debug modules can reach AXI slaves, including axi2mem-backed memories.
- Each accepted request becomes exactly one single-beat AXI transaction: len=0, size=LOG_NR_BYTES, burst INCR.
- At most one transaction is outstanding at any time.

Parameters:
AXI_ID_WIDTH, 10, width of AXI id fields
AXI_ADDR_WIDTH, 64, address width
AXI_DATA_WIDTH, 64, data width; must be a power of two and at least 8
AXI_USER_WIDTH, 10, user signal width
AXI_ID, 0, constant id driven on aw_id/ar_id

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  request valid
gnt_o  out  1  request accepted this cycle
we_i  in  1  1=write, 0=read
addr_i  in  AXI_ADDR_WIDTH  byte address
be_i  in  AXI_DATA_WIDTH/8  write byte enables
wdata_i  in  AXI_DATA_WIDTH  write data
user_i  in  AXI_USER_WIDTH  user sideband
rvalid_o  out  1  response valid, one-cycle pulse
rdata_o  out  AXI_DATA_WIDTH  read data; 0 after writes
ruser_o  out  AXI_USER_WIDTH  r_user for reads; 0 after writes
err_o  out  1  response was not OKAY; qualified by rvalid_o
master  modport  AXI_BUS.Master  AXI master port

Behaviour:
- Clocking and reset
  - Single clock clk_i; reset rst_i is synchronous and active-high.
  - On reset, all outputs are 0: gnt_o, rvalid_o, err_o, all AXI valids and readys, and the data outputs.
  - State returns to IDLE at the edge where rst_i is sampled high.
  - Reset mid-transaction abandons the in-flight AXI transfer. System reset is global, so no drain is required.
- States: IDLE, AW_W, WAIT_B, AR, WAIT_R.
- IDLE
  - gnt_o = req_i, combinational. A request is accepted on req_i && gnt_o.
  - Latch the following into an internal request register:
    - address, with the low LOG_NR_BYTES bits forced to 0
    - we, be, wdata, user
  - Next state is AW_W if we_i, else AR.
  - gnt_o is 0 in every other state.
- AW_W
  - aw_valid and w_valid are both asserted from the first cycle after the grant.
  - aw_addr = latched address; aw_len=0; aw_size=LOG_NR_BYTES; aw_burst=INCR; aw_id=AXI_ID; aw_user=latched user.
  - w_data and w_strb come from the latch; w_last=1; w_user=latched user.
  - Per-channel done flags: each valid drops in the cycle after its own handshake and stays low.
  - aw and w may complete in the same cycle or in either order.
  - Move to WAIT_B once both are done. No dependency on W before AW or the reverse.
- WAIT_B
  - b_ready=1.
  - On b_valid: next cycle rvalid_o=1, err_o=(b_resp!=OKAY), rdata_o=0; return to IDLE.
- AR
  - ar_valid=1 with the same attribute encoding as AW.
  - On ar_ready, go to WAIT_R.
- WAIT_R
  - r_ready=1.
  - On r_valid: register r_data, r_user and err=(r_resp!=OKAY).
  - Next cycle rvalid_o=1; return to IDLE.
- Response timing
  - rvalid_o is a one-cycle pulse, simultaneous with re-entry to IDLE.
  - A new request may be granted in that same cycle.
  - rdata_o holds its value until the next response.
- Minimum latency
  - Grant at cycle 0, AXI valid at cycle 1.
  - With zero-wait slave readiness: read rvalid_o at cycle 3, write rvalid_o at cycle 3.
- Response id: b_id/r_id are not checked; a single outstanding transaction guarantees the match.
- Unused signals are driven to 0:
  - aw/ar lock, cache, prot, qos, region, atop
  - b/r user where unused
- Valids never drop without a handshake, and AW/W/AR attributes are stable while valid (AXI rule).

Decomposition:
- Shared package axi_mem_pkg holds:
  - axi_burst_t (FIXED/INCR/WRAP)
  - response codes OKAY/EXOKAY/SLVERR/DECERR
  - the ax_req_t struct
  - all of these also to be used by axi2mem
- Single module; no sub-module needed.
- The request latch and the response register live in the same file.

Test Plan:
- Write addr=0x1004, wdata=0xDEADBEEF_CAFEF00D, be=0x0F; slave ready always -> aw_addr=0x1000, w_strb=0x0F, w_last=1; rvalid_o at cycle 3; err_o=0.
- Read addr=0x2000; slave returns r_data=0x1122334455667788, r_resp=OKAY after 4 wait cycles -> rdata_o equals that value on a single rvalid_o pulse; gnt_o low for the whole transaction.
- Write with w_ready asserted 3 cycles before aw_ready, then the reverse order -> exactly one handshake per channel; both valids held until their own ready; single B accepted.
- Read answered with r_resp=SLVERR, then write answered with b_resp=DECERR -> err_o=1 on each rvalid_o pulse.
- req_i held high for back-to-back read/write/read -> each new gnt_o in the rvalid_o cycle of the previous transaction; never two AXI transactions outstanding.
- rst_i asserted while in WAIT_R -> the next cycle has all valids 0 and state IDLE; a subsequent request completes normally.
